// File: rtl/inst_fetch_resp_pkg.sv
// Shared fetch definitions: fetch state encoding and the misaligned-fetch filler word.
package inst_fetch_resp_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] FS_START = 2'd0;
    localparam logic [1:0] FS_REQ   = 2'd1;
    localparam logic [1:0] FS_WAIT  = 2'd2;
    localparam logic [1:0] FS_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        ST_START = FS_START,
        ST_REQ   = FS_REQ,
        ST_WAIT  = FS_WAIT,
        ST_HOLD  = FS_HOLD
    } fetch_state_e;

    localparam logic [DATA_W-1:0] ADEL_INST_DEFAULT = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_resp.sv
// Fetch responder: issues the next-PC address on the instruction bus, holds the
// returned word for decode, and pulses PC_fresh when the fetch is consumed or dropped.
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter logic [31:0] ADEL_INST = ADEL_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_cancel,
    input  logic        de_allowin,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic        PC_fresh,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_adel
);

    fetch_state_e      r_state;
    logic              r_discard;
    logic [DATA_W-1:0] r_inst_out;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_adel;

    fetch_state_e      w_state_nxt;
    logic              w_discard_nxt;
    logic [DATA_W-1:0] w_inst_out_nxt;
    logic [ADDR_W-1:0] w_inst_pc_nxt;
    logic              w_inst_adel_nxt;
    logic              w_req;
    logic              w_fresh;
    logic              w_valid;

    // State and hold-buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_START;
            r_discard   <= 1'b0;
            r_inst_out  <= '0;
            r_inst_pc   <= '0;
            r_inst_adel <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_discard   <= w_discard_nxt;
            r_inst_out  <= w_inst_out_nxt;
            r_inst_pc   <= w_inst_pc_nxt;
            r_inst_adel <= w_inst_adel_nxt;
        end
    end

    // Next-state, buffer loads and handshake outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_discard_nxt   = r_discard;
        w_inst_out_nxt  = r_inst_out;
        w_inst_pc_nxt   = r_inst_pc;
        w_inst_adel_nxt = r_inst_adel;
        w_req           = 1'b0;
        w_fresh         = 1'b0;
        w_valid         = 1'b0;

        case (r_state)
            ST_START: begin
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                // A misaligned address never reaches the bus; it is reported as a fetch error.
                if (is_misaligned(fetch_addr)) begin
                    w_inst_out_nxt  = ADEL_INST;
                    w_inst_pc_nxt   = fetch_addr;
                    w_inst_adel_nxt = 1'b1;
                    w_state_nxt     = ST_HOLD;
                end else begin
                    w_req = 1'b1;
                    if (inst_addr_ok) begin
                        w_inst_pc_nxt   = fetch_addr;
                        w_inst_adel_nxt = 1'b0;
                        w_state_nxt     = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (inst_data_ok) begin
                    // Stale data (cancel now or earlier) is dropped and the PC advances.
                    if (r_discard || fetch_cancel) begin
                        w_discard_nxt = 1'b0;
                        w_fresh       = 1'b1;
                        w_state_nxt   = ST_REQ;
                    end else begin
                        w_inst_out_nxt = inst_rdata;
                        w_state_nxt    = ST_HOLD;
                    end
                end else if (fetch_cancel) begin
                    w_discard_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (fetch_cancel) begin
                    w_fresh     = 1'b1;
                    w_state_nxt = ST_REQ;
                end else begin
                    w_valid = 1'b1;
                    if (de_allowin) begin
                        w_fresh     = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_START;
            end
        endcase
    end

    assign inst_req   = w_req;
    assign inst_addr  = w_req ? fetch_addr : '0;
    assign PC_fresh   = w_fresh;
    assign inst_valid = w_valid;
    assign inst_out   = r_inst_out;
    assign inst_pc    = r_inst_pc;
    assign inst_adel  = r_inst_adel;

endmodule
